// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues in-order word
// requests to a variable-latency instruction memory, buffers returned words
// in a small circular queue and hands them to the datapath over valid/ready.
// Redirects flush the queue and discard responses still in flight.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_q_data [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    logic [CW:0]   w_credit;
    logic          w_fire;
    logic          w_resp;
    logic          w_resp_drop;
    logic          w_keep;
    logic          w_pop;
    logic [31:0]   w_rpc;
    logic [CW-1:0] w_inflight_nxt;

    // Every accepted request either sits in the queue or is still in flight,
    // so bounding their sum by DEPTH keeps the queue from overflowing.
    assign w_credit       = {1'b0, r_count} + {1'b0, r_inflight};
    assign imem_req_valid = !rst && (w_credit < LP_DEPTH);
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a memory protocol error and is ignored.
    assign w_resp         = imem_resp_valid && (r_inflight != '0);
    assign w_resp_drop    = w_resp && (r_drop != '0);
    // Responses arriving in a redirect cycle belong to the old path and are discarded.
    assign w_keep         = w_resp && (r_drop == '0) && !redirect_valid;
    assign w_pop          = inst_valid && inst_ready;

    // Responses return in order, so the oldest outstanding address is pc - 4*inflight.
    assign w_rpc          = r_pc - (32'(r_inflight) << 2);
    assign w_inflight_nxt = r_inflight + CW'(w_fire) - CW'(w_resp);

    assign inst_valid = !rst && (r_count != '0);
    assign inst_data  = inst_valid ? r_q_data[r_head] : '0;
    assign inst_pc    = inst_valid ? r_q_pc[r_head] : '0;
    assign inst_pc4   = inst_valid ? (r_q_pc[r_head] + 32'd4) : '0;

    // Queue storage: capture kept responses at the tail (no reset needed).
    always_ff @(posedge clk) begin
        if (!rst && w_keep) begin
            r_q_data[r_tail] <= imem_resp_data;
            r_q_pc[r_tail]   <= w_rpc;
        end
    end

    // Control state: PC, queue pointers/count, in-flight and drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (redirect_valid) begin
                // Everything still outstanding after this cycle is stale.
                r_pc    <= {redirect_pc[31:2], 2'b00};
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_drop  <= w_inflight_nxt;
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_keep) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= r_count + CW'(w_keep) - CW'(w_pop);
                r_drop  <= r_drop - CW'(w_resp_drop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a variable-latency in-order memory model plus a
// transaction-level reference (expected fetch PC, epoch-tagged outstanding
// requests, expected instruction queue) checked by a negedge monitor.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFFFFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int          due;
    } req_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    req_t        pend[$];       // requests accepted by memory, oldest first
    logic [31:0] exp_q[$];      // PCs of instructions expected in the DUT queue
    logic [31:0] m_pc     = RPC;
    int unsigned epoch    = 0;
    int          last_due = 0;
    int          lat_lo   = 1;
    int          lat_hi   = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                        input bit rr, input bit ir);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rr;
        inst_ready     = ir;
        if (!r && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memword(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    // Monitor and reference model: evaluates each cycle at the falling edge.
    always @(negedge clk) begin : monitor
        bit   fire;
        req_t r;
        int   d;
        if (rst) begin
            chk("rst_req_valid", 32'(imem_req_valid), 0);
            chk("rst_inst_valid", 32'(inst_valid), 0);
            chk("rst_inst_data", inst_data, 0);
            chk("rst_inst_pc", inst_pc, 0);
            chk("rst_inst_pc4", inst_pc4, 0);
            pend.delete();
            exp_q.delete();
            epoch++;
            m_pc     = RPC;
            last_due = 0;
        end else begin
            fire = imem_req_valid && imem_req_ready;
            chk("req_valid", 32'(imem_req_valid), 32'(exp_q.size() + pend.size() < DEPTH));
            chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("inst_pc", inst_pc, exp_q[0]);
                chk("inst_data", inst_data, memword(exp_q[0]));
                chk("inst_pc4", inst_pc4, exp_q[0] + 32'd4);
            end else begin
                chk("idle_data", inst_data, 0);
                chk("idle_pc", inst_pc, 0);
                chk("idle_pc4", inst_pc4, 0);
            end
            if (fire) chk("req_addr", imem_req_addr, m_pc);
            if (inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (imem_resp_valid) begin
                chk("resp_has_req", 32'(pend.size() != 0), 1);
                if (pend.size() != 0) begin
                    r = pend.pop_front();
                    if (!redirect_valid && r.epoch == epoch) exp_q.push_back(r.addr);
                end
            end
            if (fire) begin
                d = cyc + $urandom_range(lat_hi, lat_lo);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{addr: m_pc, epoch: epoch, due: d});
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                m_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;

        repeat (3) step(1, 0, 0, 1, 1);

        // L=1, always ready: first instruction two cycles after reset release
        lat_lo = 1; lat_hi = 1;
        step(0, 0, 0, 1, 1); @(negedge clk);
        chk("p1_c0_valid", 32'(inst_valid), 0);
        chk("p1_c0_addr", imem_req_addr, RPC);
        step(0, 0, 0, 1, 1); @(negedge clk);
        chk("p1_c1_valid", 32'(inst_valid), 0);
        step(0, 0, 0, 1, 1); @(negedge clk);
        chk("p1_c2_valid", 32'(inst_valid), 1);
        chk("p1_first_pc", inst_pc, RPC);
        step(0, 0, 0, 1, 1); @(negedge clk);
        chk("p1_wrap_pc4", inst_pc4, 32'h00000000);
        n = 0;
        repeat (20) begin
            step(0, 0, 0, 1, 1); @(negedge clk);
            if (inst_valid && inst_ready) n++;
        end
        chk("p1_throughput", 32'(n), 20);

        // Backpressure: redirect to 0 and hold inst_ready low
        step(0, 1, 32'h0, 1, 0);
        n = 0;
        repeat (8) begin
            step(0, 0, 0, 1, 0); @(negedge clk);
            if (imem_req_valid && imem_req_ready) n++;
        end
        chk("bp_fires", 32'(n), 4);
        chk("bp_stalled", 32'(imem_req_valid), 0);
        chk("bp_head_pc", inst_pc, 32'h0);
        step(0, 0, 0, 1, 1); @(negedge clk);
        chk("bp_still_stalled", 32'(imem_req_valid), 0);
        step(0, 0, 0, 1, 1); @(negedge clk);
        chk("bp_resume_valid", 32'(imem_req_valid), 1);
        chk("bp_resume_addr", imem_req_addr, 32'h10);
        repeat (6) step(0, 0, 0, 1, 1);

        // L=3 with three requests in flight, then redirect to 0x100
        lat_lo = 3; lat_hi = 3;
        n = 0;
        while (n < 30 && pend.size() != 3) begin
            step(0, 0, 0, 1, 1); @(negedge clk);
            n++;
        end
        chk("redir_inflight3", 32'(pend.size()), 3);
        step(0, 1, 32'h00000103, 1, 0);
        step(0, 0, 0, 1, 0); @(negedge clk);
        chk("redir_flush", 32'(inst_valid), 0);
        n = 0;
        while (n < 30 && !inst_valid) begin
            step(0, 0, 0, 1, 0); @(negedge clk);
            n++;
        end
        chk("redir_arrived", 32'(inst_valid), 1);
        chk("redir_pc", inst_pc, 32'h100);
        repeat (10) step(0, 0, 0, 1, 1);

        // Mid-operation reset with a partly filled queue and stale requests in flight
        repeat (4) step(0, 0, 0, 1, 0);
        step(0, 1, 32'h200, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1); @(negedge clk);
        chk("mrst_valid", 32'(inst_valid), 0);
        chk("mrst_req_valid", 32'(imem_req_valid), 1);
        chk("mrst_addr", imem_req_addr, RPC);

        // Randomized traffic: latency, backpressure, redirects, occasional reset
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit rd;
            if (i % 250 == 0) begin
                lat_lo = $urandom_range(3, 1);
                lat_hi = lat_lo + $urandom_range(3, 0);
            end
            r  = ($urandom_range(299, 0) == 0);
            rd = !r && ($urandom_range(19, 0) == 0);
            step(r, rd, $urandom, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
        end
        step(0, 0, 0, 1, 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
